// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access stage: write-back bus layout,
// FSM state encoding and error-flag bit positions.
package memory_access_pkg;

  localparam int WB_W            = 69;
  localparam int WB_IS_WRITE_BIT = 68;
  localparam int WB_ADDR_MSB     = 67;
  localparam int WB_ADDR_LSB     = 64;
  localparam int WB_VAL_MSB      = 63;

  localparam int ERR_TIMEOUT = 0;
  localparam int ERR_ILLEGAL = 1;

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  function automatic logic [WB_W-1:0] pack_wb(input logic       is_write,
                                              input logic [3:0]  reg_address,
                                              input logic [63:0] value);
    return {is_write, reg_address, value};
  endfunction

endpackage

// File: rtl/memory_access_wait_timer.sv
// Memory-wait watchdog: loads MEM_TIMEOUT-1 on clr, counts down while en,
// and flags expiry at terminal count zero.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/memory_access.sv
// Memory-access stage: ALU results pass straight to write-back, loads and
// stores go through a req/ack data-memory port guarded by a wait timer.
//
// state    | meaning
// IDLE     | ready for a new instruction; ALU ops complete here in one cycle
// MEM_WAIT | memory request outstanding, waiting for mem_ack or timeout
module memory_access
  import memory_access_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic              ex_reg_write,
  input  logic [3:0]        ex_dest,
  input  logic [63:0]       ex_alu_result,
  input  logic [63:0]       ex_store_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [WB_W-1:0]   wb_bus,
  output logic [1:0]        err_flags
);

  state_t     state;
  logic       lat_reg_write;
  logic [3:0] lat_dest;
  logic       lat_is_store;
  logic       timer_expired;

  assign ex_ready = (state == IDLE);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state == IDLE),
    .en     ((state == MEM_WAIT) && !mem_ack),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wb_bus        <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      err_flags     <= '0;
      lat_reg_write <= 1'b0;
      lat_dest      <= '0;
      lat_is_store  <= 1'b0;
    end else begin
      // The write strobe is a one-cycle pulse; the payload bits hold.
      wb_bus[WB_IS_WRITE_BIT] <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (ex_is_load && ex_is_store) begin
              err_flags[ERR_ILLEGAL] <= 1'b1;
            end else if (ex_is_load || ex_is_store) begin
              lat_reg_write <= ex_reg_write;
              lat_dest      <= ex_dest;
              lat_is_store  <= ex_is_store;
              mem_req       <= 1'b1;
              mem_we        <= ex_is_store;
              mem_addr      <= ex_alu_result[ADDR_W-1:0];
              mem_wdata     <= ex_is_store ? ex_store_data : 64'd0;
              state         <= MEM_WAIT;
            end else begin
              wb_bus <= pack_wb(ex_reg_write, ex_dest, ex_alu_result);
            end
          end
        end
        MEM_WAIT: begin
          // An ack on the expiry cycle still counts as a normal completion.
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
            if (!lat_is_store) begin
              wb_bus <= pack_wb(lat_reg_write, lat_dest, mem_rdata);
            end
          end else if (timer_expired) begin
            mem_req                <= 1'b0;
            err_flags[ERR_TIMEOUT] <= 1'b1;
            state                  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: directed scenarios followed by a
// randomized instruction stream checked against a transaction-level model.
module tb_memory_access;

  localparam int ADDR_W = 16;
  localparam int TMO    = 4;

  logic              clk;
  logic              rst_n;
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_is_load;
  logic              ex_is_store;
  logic              ex_reg_write;
  logic [3:0]        ex_dest;
  logic [63:0]       ex_alu_result;
  logic [63:0]       ex_store_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;
  logic              mem_ack;
  logic [68:0]       wb_bus;
  logic [1:0]        err_flags;

  memory_access #(
    .ADDR_W     (ADDR_W),
    .MEM_TIMEOUT(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_is_load   (ex_is_load),
    .ex_is_store  (ex_is_store),
    .ex_reg_write (ex_reg_write),
    .ex_dest      (ex_dest),
    .ex_alu_result(ex_alu_result),
    .ex_store_data(ex_store_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .wb_bus       (wb_bus),
    .err_flags    (err_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [68:0] exp_wb;
  logic [1:0]  exp_err;
  logic [63:0] mem_model [logic [15:0]];

  task automatic check(input string tag, input logic [68:0] obs, input logic [68:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".wb"}, wb_bus, exp_wb);
    check({tag, ".err"}, 69'(err_flags), 69'(exp_err));
  endtask

  function automatic logic [63:0] get_mem(input logic [15:0] a);
    if (!mem_model.exists(a)) mem_model[a] = {$urandom, $urandom};
    return mem_model[a];
  endfunction

  task automatic drive_instr(input bit ld, input bit st, input logic [3:0] dest,
                             input bit rw, input logic [63:0] alu, input logic [63:0] sdata);
    ex_valid      = 1'b1;
    ex_is_load    = ld;
    ex_is_store   = st;
    ex_reg_write  = rw;
    ex_dest       = dest;
    ex_alu_result = alu;
    ex_store_data = sdata;
  endtask

  task automatic clear_instr();
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
  endtask

  task automatic idle_cycle(input bit ack_noise);
    clear_instr();
    mem_ack   = ack_noise;
    mem_rdata = {$urandom, $urandom};
    tick();
    mem_ack = 1'b0;
    exp_wb[68] = 1'b0;
    check_outputs("idle");
    check("idle.ready", 69'(ex_ready), 69'(1));
    check("idle.req", 69'(mem_req), 69'(0));
  endtask

  task automatic do_alu(input logic [3:0] dest, input bit rw, input logic [63:0] val);
    check("alu.ready", 69'(ex_ready), 69'(1));
    drive_instr(1'b0, 1'b0, dest, rw, val, {$urandom, $urandom});
    tick();
    clear_instr();
    exp_wb = {rw, dest, val};
    check_outputs("alu");
    check("alu.req", 69'(mem_req), 69'(0));
  endtask

  task automatic do_mem(input bit ld, input bit st, input logic [3:0] dest, input bit rw,
                        input logic [63:0] alu, input logic [63:0] sdata,
                        input int ack_delay, input bit noise);
    logic [15:0] a;
    a = alu[15:0];
    check("mem.ready0", 69'(ex_ready), 69'(1));
    drive_instr(ld, st, dest, rw, alu, sdata);
    tick();
    clear_instr();
    exp_wb[68] = 1'b0;
    if (ld && st) begin
      exp_err[1] = 1'b1;
      check_outputs("illegal");
      check("illegal.req", 69'(mem_req), 69'(0));
      check("illegal.ready", 69'(ex_ready), 69'(1));
      return;
    end
    check_outputs("mem.issue");
    check("mem.req", 69'(mem_req), 69'(1));
    check("mem.we", 69'(mem_we), 69'(st));
    check("mem.addr", 69'(mem_addr), 69'(a));
    check("mem.wdata", 69'(mem_wdata), 69'(st ? sdata : 64'd0));
    check("mem.ready", 69'(ex_ready), 69'(0));
    for (int c = 0; c < TMO; c++) begin
      if (noise) drive_instr(1'b0, 1'b0, 4'($urandom), 1'b1, {$urandom, $urandom}, 64'd0);
      if (c == ack_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = ld ? get_mem(a) : {$urandom, $urandom};
        tick();
        mem_ack = 1'b0;
        clear_instr();
        if (ld) exp_wb = {rw, dest, mem_rdata};
        else mem_model[a] = sdata;
        check_outputs("mem.done");
        check("done.req", 69'(mem_req), 69'(0));
        check("done.ready", 69'(ex_ready), 69'(1));
        break;
      end else if (c == TMO - 1) begin
        tick();
        clear_instr();
        exp_err[0] = 1'b1;
        check_outputs("mem.timeout");
        check("tmo.req", 69'(mem_req), 69'(0));
        check("tmo.ready", 69'(ex_ready), 69'(1));
        break;
      end else begin
        tick();
        check_outputs("mem.wait");
        check("wait.req", 69'(mem_req), 69'(1));
        check("wait.ready", 69'(ex_ready), 69'(0));
        check("wait.addr", 69'(mem_addr), 69'(a));
        check("wait.we", 69'(mem_we), 69'(st));
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    ex_reg_write  = 1'b0;
    ex_dest       = '0;
    ex_alu_result = '0;
    ex_store_data = '0;
    clear_instr();
    exp_wb  = '0;
    exp_err = '0;

    #2;
    check_outputs("reset");
    check("reset.req", 69'(mem_req), 69'(0));
    check("reset.we", 69'(mem_we), 69'(0));
    check("reset.addr", 69'(mem_addr), 69'(0));
    check("reset.wdata", 69'(mem_wdata), 69'(0));
    check("reset.ready", 69'(ex_ready), 69'(1));
    tick();
    rst_n = 1'b1;
    idle_cycle(1'b0);

    do_alu(4'd6, 1'b1, 64'd50);
    check("alu6.wb", wb_bus, {1'b1, 4'd6, 64'd50});
    idle_cycle(1'b0);

    mem_model[16'h0010] = 64'd25;
    do_mem(1'b1, 1'b0, 4'd3, 1'b1, 64'h0010, 64'd0, 2, 1'b0);
    check("load3.wb", wb_bus, {1'b1, 4'd3, 64'd25});
    idle_cycle(1'b0);

    do_mem(1'b0, 1'b1, 4'd7, 1'b1, 64'h0020, 64'hAB, 0, 1'b0);
    idle_cycle(1'b0);

    do_mem(1'b1, 1'b0, 4'd9, 1'b1, 64'h0030, 64'd0, TMO, 1'b0);
    check("timeout.err", 69'(err_flags), 69'(2'b01));
    idle_cycle(1'b0);

    drive_instr(1'b1, 1'b0, 4'd2, 1'b1, 64'h0040, 64'd0);
    tick();
    clear_instr();
    check("rst.req_before", 69'(mem_req), 69'(1));
    tick();
    rst_n = 1'b0;
    #1;
    exp_wb  = '0;
    exp_err = '0;
    check_outputs("rst.mid");
    check("rst.req", 69'(mem_req), 69'(0));
    tick();
    rst_n = 1'b1;
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    for (int i = 1; i <= 5; i++) do_alu(4'(i), 1'b1, 64'(100 + i));
    idle_cycle(1'b0);
    do_mem(1'b1, 1'b1, 4'd8, 1'b1, 64'h0050, 64'h5, 0, 1'b0);
    check("illegal.err1", 69'(err_flags[1]), 69'(1));
    idle_cycle(1'b0);

    for (int n = 0; n < 300; n++) begin
      int          kind;
      logic [63:0] alu;
      kind = $urandom_range(0, 19);
      alu  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) idle_cycle($urandom_range(0, 2) == 0);
      if (kind < 9) begin
        do_alu(4'($urandom), $urandom_range(0, 3) != 0, alu);
      end else begin
        alu[15:0] = 16'($urandom_range(0, 15) * 8);
        do_mem(kind < 14 || kind == 19, kind >= 14, 4'($urandom), $urandom_range(0, 3) != 0,
               alu, {$urandom, $urandom}, $urandom_range(0, TMO + 1), $urandom_range(0, 1) == 1);
      end
    end
    idle_cycle(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
